traffic_sensor_conditioner: RTL and testbench
=============================================

// Module: traffic_sensor_conditioner
// PURPOSE
//  Front end for TrafficLightController. Turns raw asynchronous vehicle-loop sensors for roads A
//  and B into clean, debounced, gap-bridged presence requests on traffic_A/traffic_B.
//  Also keeps per-road saturating vehicle counts and flags sensors stuck high.
//  Single clock domain. Channels A and B are identical and fully independent.
// PARAMETERS
//  DEB_CYCLES    4    consecutive synced-high cycles that qualify a vehicle (>=1)
//  HOLD_CYCLES   8    synced-low cycles that traffic_X stays high after a vehicle leaves (>=1)
//  STUCK_CYCLES  64   consecutive synced-high cycles in PRESENT before the fault is flagged
//  CNT_W         8    vehicle counter width
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  sensor_A   in   1      raw loop sensor, road A, asynchronous
//  sensor_B   in   1      raw loop sensor, road B, asynchronous
//  count_clr  in   1      synchronous clear of count_A and count_B
//  traffic_A  out  1      conditioned presence request, road A (to TrafficLightController)
//  traffic_B  out  1      conditioned presence request, road B
//  count_A    out  CNT_W  vehicles qualified on A, saturating
//  count_B    out  CNT_W  vehicles qualified on B, saturating
//  fault_A    out  1      sticky stuck-sensor flag, A
//  fault_B    out  1      sticky stuck-sensor flag, B
// BEHAVIOUR
//  - reset=0: all flops clear immediately, without waiting for a clock. FSM=IDLE.
//    traffic_X=0, count_X=0, fault_X=0.
//  - Each sensor goes through a 2-flop synchronizer (s_X). All outputs are registered.
//  - FSM per channel, with deb_cnt, hold_cnt and stuck_cnt:
//    IDLE     traffic=0. s=1: go to QUAL with deb_cnt=1.
//    QUAL     traffic=0. s=0: go to IDLE with deb_cnt=0.
//             s=1: deb_cnt++. When deb_cnt reaches DEB_CYCLES: go to PRESENT and count++.
//    PRESENT  traffic=1. s=1: stuck_cnt++, saturating.
//             s=0: go to HOLD with hold_cnt=0, deb_cnt=0, stuck_cnt=0.
//    HOLD     traffic=1.
//             s=0: deb_cnt=0, hold_cnt++. When hold_cnt reaches HOLD_CYCLES: go to IDLE.
//             s=1: hold_cnt holds, deb_cnt++. When deb_cnt reaches DEB_CYCLES: go to PRESENT
//             and count++ (new vehicle with no traffic drop).
//  - Latency: a sensor high for DEB_CYCLES consecutive sync samples raises traffic_X
//    2+DEB_CYCLES edges after its first sampling edge. Default is 6.
//  - Shorter pulses never reach traffic_X or count_X. A QUAL restart needs a fresh IDLE entry.
//  - Fault: stuck_cnt reaching STUCK_CYCLES sets fault_X. fault_X is cleared only by reset.
//    While fault_X=1, traffic_X is forced to 1 (fail-safe: keep requesting green).
//    The FSM and counter keep running while fault_X=1.
//  - Counter: count_X saturates at 2^CNT_W-1.
//    count_clr=1 zeroes both counts on the next edge.
//    If count_clr and an increment land on the same edge, the clear wins (result 0).
//  - Equal simultaneous activity on A and B gives identical, cycle-aligned outputs.
// TESTING  (defaults, 10 ns clk)
//  1 Reset: drive reset low mid-PRESENT (count_A=3). traffic_A, count_A and fault_A go to 0
//    before the next clk edge. After release, sensor_A=0 keeps traffic_A=0.
//  2 Glitch: sensor_A high for 3 cycles, then low. traffic_A=0 throughout and count_A stays 0.
//  3 Single vehicle: sensor_A high for 10 cycles. traffic_A rises on edge 6 and count_A=1.
//    After sensor_A falls, traffic_A stays high for 2+8 edges, then returns to 0.
//  4 Back-to-back: vehicles of 6 cycles with a 4-cycle gap. traffic_A stays high with no drop
//    and count_A=2. With a 12-cycle gap, traffic_A drops between the vehicles.
//  5 Stuck: hold sensor_B high for 80 cycles. fault_B=1 64 cycles after PRESENT entry.
//    Drop sensor_B: traffic_B stays 1 indefinitely. count_B=1.
//  6 Count: 300 vehicles on A -> count_A=255. Pulse count_clr on an increment edge -> count_A=0.
//    Run A and B simultaneously: outputs are identical.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// Vehicle-loop sensor conditioner: synchronizes, debounces and gap-bridges two
// independent road sensors, with saturating vehicle counts and stuck-sensor detection.

module traffic_sensor_channel #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STUCK_CYCLES = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor,
  input  logic             count_clr,
  output logic             traffic,
  output logic [CNT_W-1:0] count,
  output logic             fault
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUAL    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]    stuck_cnt_q, stuck_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;
  logic             traffic_q, traffic_d;
  logic [DW-1:0]    deb_inc;
  logic             veh_inc;

  assign deb_inc = deb_cnt_q + DW'(1);

  always_comb begin
    sync1_d     = sensor;
    s_d         = sync1_q;
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    stuck_cnt_d = stuck_cnt_q;
    veh_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_q) begin
          deb_cnt_d = deb_inc;
          // DEB_CYCLES==1 qualifies on the very first high sample
          if (deb_inc >= DW'(DEB_CYCLES)) begin
            state_d = ST_PRESENT;
            veh_inc = 1'b1;
          end else begin
            state_d = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (!s_q) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DW'(DEB_CYCLES)) begin
            state_d = ST_PRESENT;
            veh_inc = 1'b1;
          end
        end
      end
      ST_PRESENT: begin
        if (s_q) begin
          if (stuck_cnt_q != SW'(STUCK_CYCLES)) stuck_cnt_d = stuck_cnt_q + SW'(1);
        end else begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          deb_cnt_d   = '0;
          stuck_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (!s_q) begin
          deb_cnt_d  = '0;
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (hold_cnt_d >= HW'(HOLD_CYCLES)) state_d = ST_IDLE;
        end else begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DW'(DEB_CYCLES)) begin
            state_d = ST_PRESENT;
            veh_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fault_d = fault_q | (stuck_cnt_d == SW'(STUCK_CYCLES));

    count_d = count_q;
    if (count_clr)                      count_d = '0;
    else if (veh_inc && count_q != '1)  count_d = count_q + CNT_W'(1);

    // a faulted sensor keeps requesting green regardless of the FSM
    traffic_d = (state_d == ST_PRESENT) || (state_d == ST_HOLD) || fault_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      s_q         <= 1'b0;
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      stuck_cnt_q <= '0;
      count_q     <= '0;
      fault_q     <= 1'b0;
      traffic_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      s_q         <= s_d;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      count_q     <= count_d;
      fault_q     <= fault_d;
      traffic_q   <= traffic_d;
    end
  end

  assign traffic = traffic_q;
  assign count   = count_q;
  assign fault   = fault_q;

endmodule

module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STUCK_CYCLES = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_A,
  input  logic             sensor_B,
  input  logic             count_clr,
  output logic             traffic_A,
  output logic             traffic_B,
  output logic [CNT_W-1:0] count_A,
  output logic [CNT_W-1:0] count_B,
  output logic             fault_A,
  output logic             fault_B
);

  traffic_sensor_channel #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES), .CNT_W(CNT_W)
  ) u_chan_a (
    .clk(clk), .reset(reset), .sensor(sensor_A), .count_clr(count_clr),
    .traffic(traffic_A), .count(count_A), .fault(fault_A)
  );

  traffic_sensor_channel #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES), .CNT_W(CNT_W)
  ) u_chan_b (
    .clk(clk), .reset(reset), .sensor(sensor_B), .count_clr(count_clr),
    .traffic(traffic_B), .count(count_B), .fault(fault_B)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: pulse-length table, directed corner
// sequences and randomized sensors against a run-length reference model.

module tb_traffic_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 64;
  localparam int CMAX  = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sensor_A = 1'b0, sensor_B = 1'b0, count_clr = 1'b0;
  logic       traffic_A, traffic_B, fault_A, fault_B;
  logic [7:0] count_A, count_B;

  traffic_sensor_conditioner dut (
    .clk(clk), .reset(reset), .sensor_A(sensor_A), .sensor_B(sensor_B),
    .count_clr(count_clr), .traffic_A(traffic_A), .traffic_B(traffic_B),
    .count_A(count_A), .count_B(count_B), .fault_A(fault_A), .fault_B(fault_B)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Reference model: per-road run lengths of synchronized samples
  bit m_sy1[2], m_sy2[2];
  bit m_on[2], m_veh[2], m_fault[2];
  int m_hi[2], m_gap[2], m_stuck[2], m_cnt[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sy1[c] = 0; m_sy2[c] = 0; m_on[c] = 0; m_veh[c] = 0; m_fault[c] = 0;
      m_hi[c] = 0; m_gap[c] = 0; m_stuck[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_edge(input bit a, input bit b, input bit clr);
    bit raw[2];
    bit s, qualify;
    raw[0] = a; raw[1] = b;
    for (int c = 0; c < 2; c++) begin
      s = m_sy2[c];
      m_sy2[c] = m_sy1[c];
      m_sy1[c] = raw[c];
      qualify = 0;
      if (!m_on[c]) begin
        m_hi[c] = s ? m_hi[c] + 1 : 0;
        if (m_hi[c] >= DEB) begin m_on[c] = 1; m_veh[c] = 1; qualify = 1; end
      end else if (m_veh[c]) begin
        if (s) begin
          if (m_stuck[c] < STUCK) m_stuck[c]++;
        end else begin
          m_veh[c] = 0; m_gap[c] = 0; m_stuck[c] = 0; m_hi[c] = 0;
        end
      end else begin
        if (s) begin
          m_hi[c]++;
          if (m_hi[c] >= DEB) begin m_veh[c] = 1; qualify = 1; end
        end else begin
          m_hi[c] = 0;
          m_gap[c]++;
          if (m_gap[c] >= HOLD) m_on[c] = 0;
        end
      end
      if (m_stuck[c] >= STUCK) m_fault[c] = 1;
      if (clr) m_cnt[c] = 0;
      else if (qualify && m_cnt[c] < CMAX) m_cnt[c]++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_all();
    chk("traffic_A", {31'd0, traffic_A}, {31'd0, m_on[0] | m_fault[0]});
    chk("traffic_B", {31'd0, traffic_B}, {31'd0, m_on[1] | m_fault[1]});
    chk("count_A",   {24'd0, count_A},   m_cnt[0]);
    chk("count_B",   {24'd0, count_B},   m_cnt[1]);
    chk("fault_A",   {31'd0, fault_A},   {31'd0, m_fault[0]});
    chk("fault_B",   {31'd0, fault_B},   {31'd0, m_fault[1]});
  endtask

  // drive at the falling edge, model the rising edge, compare at the next falling edge
  task automatic step(input bit a, input bit b, input bit clr);
    sensor_A = a; sensor_B = b; count_clr = clr;
    @(posedge clk);
    model_edge(a, b, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_reset();
    reset = 0; sensor_A = 0; sensor_B = 0; count_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1;
  endtask

  typedef struct {
    int len;
    int exp_cnt;
    bit exp_rise;
  } vec_t;

  vec_t tbl[6];
  int   rise_at, fall_at, fault_at;
  bit   seen, dropped, a, b, clr;

  initial begin
    tbl[0] = '{1, 0, 0};
    tbl[1] = '{2, 0, 0};
    tbl[2] = '{3, 0, 0};
    tbl[3] = '{4, 1, 1};
    tbl[4] = '{5, 1, 1};
    tbl[5] = '{10, 1, 1};

    @(negedge clk);
    apply_reset();
    chk("reset_traffic_A", {31'd0, traffic_A}, 32'd0);
    chk("reset_count_A", {24'd0, count_A}, 32'd0);

    // Pulse-length table: short pulses never qualify
    for (int i = 0; i < 6; i++) begin
      apply_reset();
      seen = 0;
      for (int k = 0; k < tbl[i].len; k++) begin step(1, 0, 0); seen |= traffic_A; end
      for (int k = 0; k < 20; k++) begin step(0, 0, 0); seen |= traffic_A; end
      chk($sformatf("tbl_len%0d_count", tbl[i].len), {24'd0, count_A}, tbl[i].exp_cnt);
      chk($sformatf("tbl_len%0d_rise", tbl[i].len), {31'd0, seen}, {31'd0, tbl[i].exp_rise});
    end

    // Reset mid-PRESENT with count_A=3, no clock edge needed
    apply_reset();
    for (int v = 0; v < 2; v++) begin
      repeat (4) step(1, 0, 0);
      repeat (12) step(0, 0, 0);
    end
    repeat (8) step(1, 0, 0);
    chk("pre_reset_count_A", {24'd0, count_A}, 32'd3);
    chk("pre_reset_traffic_A", {31'd0, traffic_A}, 32'd1);
    #2 reset = 0;
    #1;
    chk("async_traffic_A", {31'd0, traffic_A}, 32'd0);
    chk("async_count_A", {24'd0, count_A}, 32'd0);
    chk("async_fault_A", {31'd0, fault_A}, 32'd0);
    model_reset();
    sensor_A = 0;
    @(negedge clk);
    reset = 1;
    repeat (5) step(0, 0, 0);
    chk("post_reset_traffic_A", {31'd0, traffic_A}, 32'd0);

    // Single vehicle: latency and hold-off timing
    apply_reset();
    rise_at = -1; fall_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step(k <= 10, 0, 0);
      if (traffic_A && rise_at < 0) rise_at = k;
      if (!traffic_A && rise_at > 0 && fall_at < 0) fall_at = k;
    end
    chk("single_rise_edge", rise_at, 32'd6);
    chk("single_fall_edge", fall_at, 32'd21);
    chk("single_count", {24'd0, count_A}, 32'd1);

    // Back-to-back vehicles, short gap bridged, long gap not
    for (int g = 0; g < 2; g++) begin
      apply_reset();
      rise_at = -1; dropped = 0;
      for (int k = 1; k <= 60; k++) begin
        a = (k <= 6) || (k > 6 + (g ? 12 : 4) && k <= 12 + (g ? 12 : 4));
        step(a, 0, 0);
        if (traffic_A && rise_at < 0) rise_at = k;
        if (rise_at > 0 && !traffic_A && count_A < 2) dropped = 1;
      end
      chk($sformatf("b2b_gap%0d_count", g ? 12 : 4), {24'd0, count_A}, 32'd2);
      chk($sformatf("b2b_gap%0d_drop", g ? 12 : 4), {31'd0, dropped}, {31'd0, g[0]});
    end

    // Stuck sensor on B
    apply_reset();
    rise_at = -1; fault_at = -1;
    for (int k = 1; k <= 80; k++) begin
      step(0, 1, 0);
      if (traffic_B && rise_at < 0) rise_at = k;
      if (fault_B && fault_at < 0) fault_at = k;
    end
    chk("stuck_fault_delay", fault_at - rise_at, 32'd64);
    repeat (40) step(0, 0, 0);
    chk("stuck_traffic_B", {31'd0, traffic_B}, 32'd1);
    chk("stuck_fault_B", {31'd0, fault_B}, 32'd1);
    chk("stuck_count_B", {24'd0, count_B}, 32'd1);
    chk("stuck_fault_A", {31'd0, fault_A}, 32'd0);

    // Saturation and clear priority
    apply_reset();
    for (int v = 0; v < 300; v++) begin
      repeat (4) step(1, 0, 0);
      repeat (12) step(0, 0, 0);
    end
    chk("sat_count_A", {24'd0, count_A}, 32'd255);
    step(0, 0, 1);
    chk("clr_count_A", {24'd0, count_A}, 32'd0);
    repeat (5) step(1, 1, 0);
    step(1, 1, 1);
    chk("clr_wins_count_A", {24'd0, count_A}, 32'd0);
    chk("clr_wins_count_B", {24'd0, count_B}, 32'd0);
    chk("clr_wins_traffic_A", {31'd0, traffic_A}, 32'd1);
    repeat (20) step(0, 0, 0);

    // Random: identical activity on both roads, then independent
    apply_reset();
    a = 0;
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      step(a, a, $urandom_range(0, 199) == 0);
      if (traffic_A !== traffic_B || count_A !== count_B || fault_A !== fault_B)
        chk("sym_outputs", {traffic_B, fault_B, 22'd0, count_B}, {traffic_A, fault_A, 22'd0, count_A});
    end
    apply_reset();
    a = 0; b = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 4) == 0) a = ~a;
      if ($urandom_range(0, 7) == 0) b = ~b;
      if (k > 1500) b = 1;
      clr = ($urandom_range(0, 149) == 0);
      step(a, b, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
